// File: rtl/mcpu_ctrl_if.sv
// Control-unit <-> datapath bundle: IR, memory handshake and every datapath strobe.
// master = control unit (drives strobes), slave = datapath (drives IR / ready / zero).
interface mcpu_ctrl_if;
  logic [31:0] Inst;
  logic        MIO_ready;
  logic        zero;
  logic        MemRead;
  logic        MemWrite;
  logic        CPU_MIO;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALU_operation;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic        shift;
  logic        unsign;
  logic [4:0]  state_out;

  modport master (
    input  Inst, MIO_ready, zero,
    output MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegDst, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, ALU_operation, PCSource, PCWrite, PCWriteCond,
           Branch, shift, unsign, state_out
  );

  modport slave (
    output Inst, MIO_ready, zero,
    input  MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegDst, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, ALU_operation, PCSource, PCWrite, PCWriteCond,
           Branch, shift, unsign, state_out
  );
endinterface

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS-subset control unit: Moore FSM whose strobes are registered
// alongside the state, so each output set is decoded from the state being entered.
module mcpu_ctrl (
  input  logic       clk,
  input  logic       reset,
  mcpu_ctrl_if.master bus
);

  typedef enum logic [4:0] {
    S_IF    = 5'd0,
    S_ID    = 5'd1,
    S_MA    = 5'd2,
    S_MR    = 5'd3,
    S_LW_WB = 5'd4,
    S_MW    = 5'd5,
    S_R_EX  = 5'd6,
    S_R_WB  = 5'd7,
    S_BR    = 5'd8,
    S_J     = 5'd9,
    S_I_EX  = 5'd10,
    S_I_WB  = 5'd11,
    S_LUI   = 5'd12,
    S_JAL   = 5'd13,
    S_JR    = 5'd14
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;   // qualified by MIO_ready at the port
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch;
    logic       shift;
    logic       unsign;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                         OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101,
                         OP_XORI  = 6'b001110, OP_LUI  = 6'b001111, OP_LW   = 6'b100011,
                         OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                         FN_OR  = 6'b100101, FN_XOR = 6'b100110, FN_NOR = 6'b100111,
                         FN_SLT = 6'b101010, FN_SRL = 6'b000010, FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011,
                         ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_t     state, state_nxt;
  ctl_t       ctl;
  logic [5:0] op, fun;
  logic       unused_ok;

  assign op  = bus.Inst[31:26];
  assign fun = bus.Inst[5:0];
  // zero is monitor-only; the branch decision lives in the datapath.
  assign unused_ok = &{1'b0, bus.zero, bus.Inst[25:6]};

  function automatic logic r_fun_legal(input logic [5:0] f);
    return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SRL};
  endfunction

  function automatic ctl_t decode(input state_t s, input logic [5:0] o, input logic [5:0] f);
    ctl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_read = 1'b1;  c.ir_write = 1'b1;     c.alu_src_b = 2'b01;
        c.alu_op   = ALU_ADD; c.pc_write = 1'b1;
      end
      S_ID:    begin c.alu_src_b = 2'b11; c.alu_op = ALU_ADD; end
      S_MA:    begin c.alu_src_a = 1'b1;  c.alu_src_b = 2'b10; c.alu_op = ALU_ADD; end
      S_MR:    begin c.mem_read  = 1'b1;  c.iord = 1'b1; end
      S_LW_WB: begin c.reg_write = 1'b1;  c.mem_to_reg = 2'b01; end
      S_MW:    begin c.mem_write = 1'b1;  c.iord = 1'b1; end
      S_R_EX: begin
        c.alu_src_a = 1'b1;
        case (f)
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_XOR:  c.alu_op = ALU_XOR;
          FN_NOR:  c.alu_op = ALU_NOR;
          FN_SLT:  c.alu_op = ALU_SLT;
          FN_SRL:  begin c.alu_op = ALU_SRL; c.shift = 1'b1; end
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_R_WB: begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
      S_BR: begin
        c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.branch = (o == OP_BEQ);
      end
      S_J:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_JAL: begin
        c.pc_write  = 1'b1; c.pc_source = 2'b10;
        c.reg_write = 1'b1; c.reg_dst   = 2'b10; c.mem_to_reg = 2'b11;
      end
      S_JR:  begin c.pc_write = 1'b1; c.pc_source = 2'b11; end
      S_I_EX: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        case (o)
          OP_SLTI: c.alu_op = ALU_SLT;
          OP_ANDI: begin c.alu_op = ALU_AND; c.unsign = 1'b1; end
          OP_ORI:  begin c.alu_op = ALU_OR;  c.unsign = 1'b1; end
          OP_XORI: begin c.alu_op = ALU_XOR; c.unsign = 1'b1; end
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB: c.reg_write = 1'b1;
      S_LUI:  begin c.reg_write = 1'b1; c.mem_to_reg = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF: state_nxt = bus.MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (op)
          OP_LW, OP_SW:   state_nxt = S_MA;
          OP_RTYPE:       state_nxt = (fun == FN_JR)    ? S_JR :
                                      r_fun_legal(fun) ? S_R_EX : S_IF;
          OP_BEQ, OP_BNE: state_nxt = S_BR;
          OP_J:           state_nxt = S_J;
          OP_JAL:         state_nxt = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_nxt = S_I_EX;
          OP_LUI:         state_nxt = S_LUI;
          default:        state_nxt = S_IF;
        endcase
      end
      S_MA:    state_nxt = (op == OP_SW) ? S_MW : S_MR;
      S_MR:    state_nxt = bus.MIO_ready ? S_LW_WB : S_MR;
      S_MW:    state_nxt = bus.MIO_ready ? S_IF : S_MW;
      S_R_EX:  state_nxt = S_R_WB;
      S_I_EX:  state_nxt = S_I_WB;
      S_BR, S_J, S_JAL, S_JR: state_nxt = bus.MIO_ready ? S_IF : state;
      default: state_nxt = S_IF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IF;
      ctl   <= decode(S_IF, op, fun);
    end else begin
      state <= state_nxt;
      ctl   <= decode(state_nxt, op, fun);
    end
  end

  assign bus.MemRead       = ctl.mem_read;
  assign bus.MemWrite      = ctl.mem_write;
  assign bus.CPU_MIO       = ctl.mem_read | ctl.mem_write;
  assign bus.IorD          = ctl.iord;
  assign bus.IRWrite       = ctl.ir_write & bus.MIO_ready;
  assign bus.RegDst        = ctl.reg_dst;
  assign bus.RegWrite      = ctl.reg_write;
  assign bus.MemtoReg      = ctl.mem_to_reg;
  assign bus.ALUSrcA       = ctl.alu_src_a;
  assign bus.ALUSrcB       = ctl.alu_src_b;
  assign bus.ALU_operation = ctl.alu_op;
  assign bus.PCSource      = ctl.pc_source;
  assign bus.PCWrite       = ctl.pc_write;
  assign bus.PCWriteCond   = ctl.pc_write_cond;
  assign bus.Branch        = ctl.branch;
  assign bus.shift         = ctl.shift;
  assign bus.unsign        = ctl.unsign;
  assign bus.state_out     = state;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Scoreboard bench for mcpu_ctrl: each scenario queues per-cycle expected state and
// strobes (from a spec-derived state table), then drives the cycles and compares.
module tb_mcpu_ctrl;

  logic clk;
  logic reset;
  mcpu_ctrl_if bus ();

  mcpu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] inst;
    logic        rdy;
    logic        rst;
    logic [27:0] vec;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [27:0] obs;

  // Expected {state, strobes} for one cycle, written straight from the state table.
  function automatic logic [27:0] exp_vec(input logic [4:0] st, input logic [31:0] inst,
                                          input logic rdy);
    logic       mr, mw, iord, irw, rw, asa, pcw, pcwc, br, sh, us;
    logic [1:0] rd, m2r, asb, pcs;
    logic [2:0] aop;
    {mr, mw, iord, irw, rw, asa, pcw, pcwc, br, sh, us} = '0;
    {rd, m2r, asb, pcs} = '0;
    aop = 3'b000;
    case (st)
      5'd0:  begin mr = 1; irw = rdy; asb = 2'b01; aop = 3'b010; pcw = 1; end
      5'd1:  begin asb = 2'b11; aop = 3'b010; end
      5'd2:  begin asa = 1; asb = 2'b10; aop = 3'b010; end
      5'd3:  begin mr = 1; iord = 1; end
      5'd4:  begin rw = 1; m2r = 2'b01; end
      5'd5:  begin mw = 1; iord = 1; end
      5'd6: begin
        asa = 1;
        case (inst[5:0])
          6'b100000: aop = 3'b010;
          6'b100010: aop = 3'b110;
          6'b100100: aop = 3'b000;
          6'b100101: aop = 3'b001;
          6'b100110: aop = 3'b011;
          6'b100111: aop = 3'b100;
          6'b101010: aop = 3'b111;
          6'b000010: begin aop = 3'b101; sh = 1; end
          default:   aop = 3'bxxx;
        endcase
      end
      5'd7:  begin rw = 1; rd = 2'b01; end
      5'd8:  begin asa = 1; aop = 3'b110; pcwc = 1; pcs = 2'b01; br = (inst[31:26] == 6'b000100); end
      5'd9:  begin pcw = 1; pcs = 2'b10; end
      5'd10: begin
        asa = 1; asb = 2'b10;
        case (inst[31:26])
          6'b001000: aop = 3'b010;
          6'b001010: aop = 3'b111;
          6'b001100: begin aop = 3'b000; us = 1; end
          6'b001101: begin aop = 3'b001; us = 1; end
          6'b001110: begin aop = 3'b011; us = 1; end
          default:   aop = 3'bxxx;
        endcase
      end
      5'd11: rw = 1;
      5'd12: begin rw = 1; m2r = 2'b10; end
      5'd13: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b11; end
      5'd14: begin pcw = 1; pcs = 2'b11; end
      default: ;
    endcase
    return {st, mr, mw, mr | mw, iord, irw, rd, rw, m2r, asa, asb, aop, pcs, pcw, pcwc, br, sh, us};
  endfunction

  // seq: one hex digit per cycle (state code), rdy/rst: one bit per cycle, read left to right.
  task automatic push_expect(input string tag, input logic [31:0] inst, input int n,
                             input logic [63:0] seq, input logic [15:0] rdy,
                             input logic [15:0] rst);
    for (int i = 0; i < n; i++) begin
      sb_entry_t   e;
      logic [4:0]  st;
      st     = {1'b0, seq[(n-1-i)*4 +: 4]};
      e.tag  = tag;
      e.inst = inst;
      e.rdy  = rdy[n-1-i];
      e.rst  = rst[n-1-i];
      e.vec  = exp_vec(st, inst, e.rdy);
      sb.push_back(e);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input logic [31:0] inst, input logic rdy, input logic rst);
    bus.Inst      = inst;
    bus.MIO_ready = rdy;
    reset         = rst;
    @(negedge clk);
    obs = {bus.state_out, bus.MemRead, bus.MemWrite, bus.CPU_MIO, bus.IorD, bus.IRWrite,
           bus.RegDst, bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
           bus.ALU_operation, bus.PCSource, bus.PCWrite, bus.PCWriteCond, bus.Branch,
           bus.shift, bus.unsign};
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    sb_entry_t e;
    push_expect("reset_idle", 32'h0000_0000, 2, 64'h00, 16'b00, 16'b00);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      step(e.inst, e.rdy, e.rst);
      checks++;
      if (obs !== e.vec) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.vec);
      end
    end
  endtask

  task automatic test_r_type();
    sb_entry_t e;
    push_expect("add", 32'h0022_1820, 4, 64'h0167, 16'b1111, 16'b0);
    push_expect("srl", 32'h0002_1882, 4, 64'h0167, 16'b1111, 16'b0);
    push_expect("jr",  32'h03E0_0008, 3, 64'h01E,  16'b111,  16'b0);
    push_expect("bad_fun", 32'h0000_0001, 2, 64'h01, 16'b11, 16'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      step(e.inst, e.rdy, e.rst);
      checks++;
      if (obs !== e.vec) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.vec);
      end
    end
  endtask

  task automatic test_mem_stall();
    sb_entry_t e;
    push_expect("lw_stall", 32'h8C22_0004, 8, 64'h0123_3334, 16'b1110_0011, 16'b0);
    push_expect("sw_if_stall", 32'hAC22_0004, 5, 64'h00125, 16'b01111, 16'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      step(e.inst, e.rdy, e.rst);
      checks++;
      if (obs !== e.vec) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.vec);
      end
    end
  endtask

  task automatic test_branch_jump();
    sb_entry_t e;
    push_expect("beq", 32'h1022_0003, 3, 64'h018, 16'b111, 16'b0);
    push_expect("bne", 32'h1422_0003, 3, 64'h018, 16'b111, 16'b0);
    push_expect("beq_stall", 32'h1022_0003, 4, 64'h0188, 16'b1101, 16'b0);
    push_expect("jal", 32'h0C00_0010, 3, 64'h01D, 16'b111, 16'b0);
    push_expect("j_stall", 32'h0800_0010, 5, 64'h01999, 16'b11001, 16'b0);
    push_expect("jr_stall", 32'h03E0_0008, 4, 64'h01EE, 16'b1101, 16'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      step(e.inst, e.rdy, e.rst);
      checks++;
      if (obs !== e.vec) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.vec);
      end
    end
  endtask

  task automatic test_i_type();
    sb_entry_t e;
    push_expect("ori",  32'h3422_0F0F, 4, 64'h01AB, 16'b1111, 16'b0);
    push_expect("addi", 32'h2022_FFFF, 4, 64'h01AB, 16'b1111, 16'b0);
    push_expect("lui",  32'h3C02_1234, 3, 64'h01C,  16'b111,  16'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      step(e.inst, e.rdy, e.rst);
      checks++;
      if (obs !== e.vec) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.vec);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    sb_entry_t e;
    push_expect("rst_in_mr", 32'h8C22_0004, 6, 64'h01_2330, 16'b111000, 16'b000010);
    push_expect("illegal_op", 32'hFC00_0000, 3, 64'h010, 16'b110, 16'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      step(e.inst, e.rdy, e.rst);
      checks++;
      if (obs !== e.vec) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_entry_t   e;
    logic [31:0] r_ops [6];
    r_ops = '{32'h0022_1822, 32'h0022_1824, 32'h0022_1825,
              32'h0022_1826, 32'h0022_1827, 32'h0022_182A};
    for (int i = 0; i < 6; i++) begin
      push_expect("r_b2b", r_ops[i], 4, 64'h0167, 16'b1111, 16'b0);
      push_expect("lui_b2b", 32'h3C01_0000 | 32'($urandom_range(0, 16'hFFFF)), 3, 64'h01C,
                  16'b111, 16'b0);
    end
    push_expect("andi_b2b", 32'h3022_FFFF, 4, 64'h01AB, 16'b1111, 16'b0);
    push_expect("xori_b2b", 32'h3822_FFFF, 4, 64'h01AB, 16'b1111, 16'b0);
    push_expect("slti_b2b", 32'h2822_FFFF, 4, 64'h01AB, 16'b1111, 16'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      step(e.inst, e.rdy, e.rst);
      checks++;
      if (obs !== e.vec) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.vec);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.Inst      = 32'h0;
    bus.MIO_ready = 1'b0;
    bus.zero      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_r_type();
    test_mem_stall();
    test_branch_jump();
    test_i_type();
    test_reset_mid_access();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
